// File: rtl/axis_arb_pkg.sv
// Shared types and default sizing for the packet-granular AXI-Stream arbiter.
package axis_arb_pkg;

  typedef enum logic {IDLE, XFER} arb_state_t;

  localparam int DEF_DW      = 16;
  localparam int DEF_NS      = 4;
  localparam int DEF_MAX_LEN = 2048;
  localparam int DEF_LW      = 12;

endpackage

// File: rtl/axis_pkt_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr, wrapping modulo NS.
module rr_pick #(
  parameter int NS = 4,
  parameter int IW = $clog2(NS)
) (
  input  logic [NS-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    // Walk offsets from farthest to nearest so the request closest to ptr wins.
    for (int i = NS - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NS]) begin
        gnt_idx = IW'((int'(ptr) + i) % NS);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one AXI-Stream FIFO; grant is held from
// the first beat until the tlast handshake, and packets longer than MAX_LEN are split.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int NS      = DEF_NS,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LW      = DEF_LW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NS*DW-1:0]      s_tdata,
  input  logic [NS-1:0]         s_tvalid,
  input  logic [NS-1:0]         s_tlast,
  output logic [NS-1:0]         s_tready,
  output logic [DW-1:0]         m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [$clog2(NS)-1:0] m_tid,
  output logic                  busy,
  output logic                  trunc_err
);

  localparam int IW = $clog2(NS);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] grant, rr_ptr, pick_idx;
  logic          pick_vld;
  logic [LW-1:0] beat_cnt;
  logic          at_max;
  logic          beat;

  rr_pick #(.NS(NS), .IW(IW)) u_pick (
    .req     (s_tvalid),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  assign at_max = (beat_cnt == LW'(MAX_LEN - 1));
  assign beat   = m_tvalid & m_tready;
  assign busy   = (state == XFER);
  assign m_tid  = grant;

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    state_nxt = state;
    s_tready  = '0;
    m_tdata   = '0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) state_nxt = XFER;
      end
      XFER: begin
        m_tvalid        = s_tvalid[grant];
        m_tdata         = s_tdata[int'(grant)*DW +: DW];
        m_tlast         = s_tlast[grant] | at_max;
        s_tready[grant] = m_tready;
        if (s_tvalid[grant] && m_tready && (s_tlast[grant] || at_max)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      trunc_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      // A forced tlast without the source's own tlast means the packet was cut short.
      trunc_err <= beat & at_max & ~s_tlast[grant];
      if (state == IDLE) begin
        if (pick_vld) begin
          grant    <= pick_idx;
          beat_cnt <= '0;
        end
      end else if (beat) begin
        if (m_tlast) begin
          rr_ptr   <= (grant == IW'(NS - 1)) ? '0 : grant + 1'b1;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench: per-source packet queues drive the arbiter, a behavioural model
// predicts every output each cycle, and directed scenarios pin the model with literals.
module tb_axis_pkt_arbiter;

  localparam int DW      = 16;
  localparam int NS      = 4;
  localparam int MAX_LEN = 8;
  localparam int LW      = 4;
  localparam int IW      = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS-1:0]     s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid, m_tlast, m_tready;
  logic [IW-1:0]     m_tid;
  logic              busy, trunc_err;

  always #5 clk = ~clk;

  axis_pkt_arbiter #(.DW(DW), .NS(NS), .MAX_LEN(MAX_LEN), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .m_tid     (m_tid),
    .busy      (busy),
    .trunc_err (trunc_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Source side: each entry is {last, data}; beats leave the queue on handshake.
  logic [DW:0]   srcq [NS][$];
  int            valid_pct = 100;
  int            rdy_mode  = 0;
  logic          tog       = 1'b1;
  logic [NS-1:0] hs        = '0;
  logic [NS-1:0] vld       = '0;

  task automatic push_pkt(input int src, input logic [DW-1:0] base, input int len);
    for (int k = 0; k < len; k++) srcq[src].push_back({(k == len - 1), base + DW'(k)});
  endtask

  function automatic bit queues_empty();
    bit e = 1'b1;
    for (int i = 0; i < NS; i++) if (srcq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NS; i++) begin
      if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      if (srcq[i].size() == 0) vld[i] = 1'b0;
      else if (!(vld[i] && !hs[i])) vld[i] = ($urandom_range(99) < valid_pct);
      s_tvalid[i]          = vld[i];
      s_tdata[i*DW +: DW]  = (srcq[i].size() > 0) ? srcq[i][0][DW-1:0] : '0;
      s_tlast[i]           = (srcq[i].size() > 0) ? srcq[i][0][DW] : 1'b0;
    end
    case (rdy_mode)
      1:       begin m_tready = tog; tog = ~tog; end
      2:       m_tready = ($urandom_range(3) != 0);
      default: m_tready = 1'b1;
    endcase
  end

  // Reference model: who owns the output, where the round-robin search starts,
  // how many beats of the current packet have gone through.
  int            owner = -1;
  int            exp_tid = 0;
  int            ptr = 0;
  int            cnt = 0;
  logic          trunc_next = 1'b0;
  logic          e_valid, e_last;
  logic [DW-1:0] e_data;
  logic [NS-1:0] e_rdy;

  // Observation logs for the directed scenarios.
  logic          pkt_start = 1'b1;
  int            beat_total = 0;
  int            trunc_cnt = 0;
  logic [DW-1:0] data_log[$];
  logic [DW-1:0] last_log[$];
  int            tid_log[$];

  always @(negedge clk) begin
    if (rst) begin
      owner = -1; exp_tid = 0; ptr = 0; cnt = 0; trunc_next = 1'b0; pkt_start = 1'b1;
      check("rst_s_tready",  32'(s_tready),  0);
      check("rst_m_tvalid",  32'(m_tvalid),  0);
      check("rst_m_tlast",   32'(m_tlast),   0);
      check("rst_m_tdata",   32'(m_tdata),   0);
      check("rst_m_tid",     32'(m_tid),     0);
      check("rst_busy",      32'(busy),      0);
      check("rst_trunc_err", 32'(trunc_err), 0);
    end else begin
      e_valid = 1'b0; e_data = '0; e_last = 1'b0; e_rdy = '0;
      if (owner >= 0) begin
        e_valid = s_tvalid[owner];
        e_data  = s_tdata[owner*DW +: DW];
        e_last  = s_tlast[owner] || (cnt == MAX_LEN - 1);
        e_rdy   = m_tready ? (NS'(1) << owner) : '0;
      end
      check("m_tvalid",  32'(m_tvalid),  32'(e_valid));
      check("m_tdata",   32'(m_tdata),   32'(e_data));
      check("m_tlast",   32'(m_tlast),   32'(e_last));
      check("s_tready",  32'(s_tready),  32'(e_rdy));
      check("m_tid",     32'(m_tid),     32'(exp_tid));
      check("busy",      32'(busy),      32'(owner >= 0));
      check("trunc_err", 32'(trunc_err), 32'(trunc_next));

      if (m_tvalid && m_tready) begin
        beat_total++;
        data_log.push_back(m_tdata);
        if (pkt_start) tid_log.push_back(int'(m_tid));
        pkt_start = m_tlast;
        if (m_tlast) last_log.push_back(m_tdata);
      end
      if (trunc_err) trunc_cnt++;

      trunc_next = 1'b0;
      if (owner < 0) begin
        for (int k = 0; k < NS; k++) begin
          if (owner < 0 && s_tvalid[(ptr + k) % NS]) begin
            owner = (ptr + k) % NS; exp_tid = owner; cnt = 0;
          end
        end
      end else if (e_valid && m_tready) begin
        if (e_last) begin
          trunc_next = (cnt == MAX_LEN - 1) && !s_tlast[owner];
          ptr   = (owner + 1) % NS;
          owner = -1;
        end else begin
          cnt++;
        end
      end
    end
    hs = s_tvalid & s_tready;
  end

  task automatic clear_logs();
    data_log.delete(); last_log.delete(); tid_log.delete(); trunc_cnt = 0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < max) begin
      @(negedge clk); #1;
      n++;
      done = !busy && queues_empty() && (s_tvalid == '0);
    end
    check("drain_timeout", 32'(done), 1);
    @(posedge clk); #2;
  endtask

  int exp_rr[5] = '{0, 1, 2, 3, 0};
  int b0, n, s;

  initial begin
    rst = 1'b0; m_tready = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    #1 rst = 1'b1;

    // Reset with every source requesting, then a round-robin pass over all sources.
    for (int i = 0; i < NS; i++) push_pkt(i, DW'(i << 8), 4);
    push_pkt(0, 16'h0004, 4);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    check("release_busy", 32'(busy), 1);
    check("release_tid", 32'(m_tid), 0);
    wait_idle(200);
    check("rr_count", 32'(tid_log.size()), 5);
    for (int k = 0; k < 5; k++)
      check("rr_order", 32'((k < tid_log.size()) ? tid_log[k] : -1), 32'(exp_rr[k]));
    check("rr_data_src1", 32'((data_log.size() > 4) ? data_log[4] : '1), 32'h0100);
    check("rr_data_last", 32'((data_log.size() > 19) ? data_log[19] : '1), 32'h0007);

    // Alternating backpressure on an 8-beat packet from source 2.
    clear_logs(); rdy_mode = 1;
    push_pkt(2, 16'h0200, 8);
    wait_idle(100);
    rdy_mode = 0;
    check("bp_beats", 32'(data_log.size()), 8);
    for (int k = 0; k < 8; k++)
      check("bp_data", 32'((k < data_log.size()) ? data_log[k] : '1), 32'(16'h0200 + k));
    check("bp_tlast_cnt", 32'(last_log.size()), 1);
    check("bp_tlast_data", 32'((last_log.size() > 0) ? last_log[0] : '1), 32'h0207);

    // A 10-beat packet is cut at MAX_LEN=8; the tail becomes a second packet.
    clear_logs();
    push_pkt(1, 16'h0100, 10);
    wait_idle(100);
    check("trunc_pkts", 32'(tid_log.size()), 2);
    check("trunc_tid0", 32'((tid_log.size() > 0) ? tid_log[0] : -1), 1);
    check("trunc_tid1", 32'((tid_log.size() > 1) ? tid_log[1] : -1), 1);
    check("trunc_last0", 32'((last_log.size() > 0) ? last_log[0] : '1), 32'h0107);
    check("trunc_last1", 32'((last_log.size() > 1) ? last_log[1] : '1), 32'h0109);
    check("trunc_pulses", 32'(trunc_cnt), 1);

    // Reset in the middle of a packet; rr pointer must restart at 0 (src 3 would win otherwise).
    clear_logs();
    push_pkt(0, 16'h0000, 6);
    b0 = beat_total; n = 0;
    while (beat_total < b0 + 3 && n < 100) begin @(negedge clk); #1; n++; end
    check("midrst_reach", 32'(beat_total >= b0 + 3), 1);
    @(posedge clk); #2 rst = 1'b1;
    push_pkt(3, 16'h0300, 3);
    @(negedge clk); #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_tvalid", 32'(m_tvalid), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    check("midrst_busy_after", 32'(busy), 1);
    check("midrst_tid", 32'(m_tid), 0);
    wait_idle(200);

    // Random traffic, random source stalls and sink backpressure, two asynchronous resets.
    valid_pct = 70; rdy_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(9) == 0) begin
        s = $urandom_range(NS - 1);
        if (srcq[s].size() < 30) push_pkt(s, DW'($urandom), $urandom_range(12, 1));
      end
      if (c == 1000 || c == 2200) begin
        rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
      end
    end
    wait_idle(5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
